// File: rtl/text_console_pkg.sv
// Shared types and constants for the text console writer.
//   state_t          : console FSM state encoding
//   LF/CR/BS/FF      : control codes handled by the decoder
//   PRINT_LO/HI      : printable character range (inclusive)
//   ADDR_W / DATA_W  : SDRAM channel address and data widths
package text_console_pkg;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 8;

  typedef enum logic [3:0] {
    IDLE,
    DECODE,
    PUT,
    PUT_WAIT,
    SCR_RD,
    SCR_RD_WAIT,
    SCR_WR,
    SCR_WR_WAIT,
    BLANK,
    BLANK_WAIT,
    DONE
  } state_t;

  localparam logic [7:0] LF       = 8'h0A;
  localparam logic [7:0] CR       = 8'h0D;
  localparam logic [7:0] BS       = 8'h08;
  localparam logic [7:0] FF       = 8'h0C;
  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= PRINT_LO) && (c <= PRINT_HI);
  endfunction

endpackage

// File: rtl/sdram_ch_req.sv
// Single-request SDRAM channel handshake.
// A one-cycle req launches a read or write: the strobe and address are
// registered and held until ch_busy has been seen high and then low. On the
// cycle busy is seen low the strobe drops, read data is captured and done
// pulses for one cycle. Reset drops the strobe asynchronously; an abandoned
// access is not retried.
// Ports:
//   clk_sys, rst_n        clock, async active-low reset
//   req, is_write         request pulse and direction (only taken while idle)
//   addr, wdata           request address and write data
//   done, rdata           completion pulse, captured read data
//   ch_addr/ch_wr/ch_rd/ch_din/ch_dout/ch_busy  channel pins
module sdram_ch_req
  import text_console_pkg::*;
(
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              req,
  input  logic              is_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ch_addr,
  output logic              ch_wr,
  output logic              ch_rd,
  output logic [DATA_W-1:0] ch_din,
  input  logic [DATA_W-1:0] ch_dout,
  input  logic              ch_busy
);

  logic busy_seen_q;
  logic active;

  assign active = ch_wr | ch_rd;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      ch_wr       <= 1'b0;
      ch_rd       <= 1'b0;
      ch_addr     <= '0;
      ch_din      <= '0;
      rdata       <= '0;
      done        <= 1'b0;
      busy_seen_q <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!active) begin
        if (req) begin
          ch_wr       <= is_write;
          ch_rd       <= !is_write;
          ch_addr     <= addr;
          busy_seen_q <= 1'b0;
          if (is_write) ch_din <= wdata;
        end
      end else if (ch_busy) begin
        busy_seen_q <= 1'b1;
      end else if (busy_seen_q) begin
        ch_wr       <= 1'b0;
        ch_rd       <= 1'b0;
        done        <= 1'b1;
        busy_seen_q <= 1'b0;
        if (ch_rd) rdata <= ch_dout;
      end
    end
  end

endmodule

// File: rtl/text_console_writer.sv
// Text console writer: turns an ASCII byte stream into character-cell writes
// in the SDRAM screen buffer, with a COLS x ROWS cursor, newline, carriage
// return, backspace, line wrap and hardware scroll (copy rows up, blank the
// last row). Pulses dirty for one cycle when a command that wrote memory ends.
// Optional feature macro: TEXT_CONSOLE_CLEAR_EN -- form feed (0x0C) blanks
// the whole screen and homes the cursor; one clear also runs automatically
// after reset when mem_ready first rises.
// Ports:
//   clk_sys, rst_n                 clock, async active-low reset
//   mem_ready                      SDRAM initialised; gates acceptance
//   in_valid, in_data, in_ready    byte input handshake
//   ch_addr/ch_wr/ch_rd/ch_din/ch_dout/ch_busy  SDRAM channel
//   cursor_col, cursor_row         current cursor
//   dirty                          one-cycle buffer-changed pulse
//
// state       | meaning
// IDLE        | waiting for a byte (or the pending clear)
// DECODE      | classify latched byte, update cursor for controls
// PUT         | issue character / backspace-fill write
// PUT_WAIT    | wait write done, advance cursor for printables
// SCR_RD      | issue scroll read of cell i+COLS
// SCR_RD_WAIT | wait read data
// SCR_WR      | issue scroll write of cell i
// SCR_WR_WAIT | wait write done, next cell or blank last row
// BLANK       | issue FILL_CHAR write of cell i
// BLANK_WAIT  | wait write done, next cell or finish
// DONE        | pulse dirty if anything was written
module text_console_writer
  import text_console_pkg::*;
#(
  parameter int          COLS      = 40,
  parameter int          ROWS      = 30,
  parameter logic [24:0] BASE_ADDR = 25'h0002000,
  parameter logic [7:0]  FILL_CHAR = 8'h20
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        mem_ready,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [24:0] ch_addr,
  output logic        ch_wr,
  output logic        ch_rd,
  output logic [7:0]  ch_din,
  input  logic [7:0]  ch_dout,
  input  logic        ch_busy,
  output logic [5:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        dirty
);

  localparam logic [10:0] LAST_IDX     = 11'(COLS * ROWS - 1);
  localparam logic [10:0] COPY_LAST    = 11'(COLS * (ROWS - 1) - 1);
  localparam logic [10:0] LAST_ROW_IDX = 11'(COLS * (ROWS - 1));
  localparam logic [10:0] COLS_W       = 11'(COLS);
  localparam logic [5:0]  LAST_COL     = 6'(COLS - 1);
  localparam logic [4:0]  LAST_ROW     = 5'(ROWS - 1);

  state_t      state_q, state_d;
  logic [7:0]  byte_q;
  logic [5:0]  col_q;
  logic [4:0]  row_q;
  logic [10:0] idx_q;
  logic [10:0] scr_idx_q;
  logic        wrote_q;
  logic        live_q;

  logic        req, req_wr;
  logic [24:0] req_addr;
  logic [7:0]  req_wdata;
  logic        done;
  logic [7:0]  rdata;

  logic        accept, clear_start, is_ff, put_print;

`ifdef TEXT_CONSOLE_CLEAR_EN
  logic clear_pend_q;
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n)           clear_pend_q <= 1'b1;
    else if (clear_start) clear_pend_q <= 1'b0;
  end
  assign clear_start = (state_q == IDLE) && mem_ready && live_q && clear_pend_q;
  assign is_ff       = (byte_q == FF);
`else
  assign clear_start = 1'b0;
  assign is_ff       = 1'b0;
`endif

  // live_q keeps in_ready low through reset even when mem_ready is already high
  assign in_ready   = (state_q == IDLE) && mem_ready && live_q && !clear_start;
  assign accept     = in_valid && in_ready;
  assign put_print  = is_printable(byte_q);
  assign dirty      = (state_q == DONE) && wrote_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req       = 1'b0;
    req_wr    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    unique case (state_q)
      IDLE: begin
        if (clear_start)  state_d = BLANK;
        else if (accept)  state_d = DECODE;
      end
      DECODE: begin
        if (put_print)                          state_d = PUT;
        else if ((byte_q == BS) && (col_q != '0)) state_d = PUT;
        else if ((byte_q == LF) && (row_q == LAST_ROW)) state_d = SCR_RD;
        else if (is_ff)                         state_d = BLANK;
        else                                    state_d = DONE;
      end
      PUT: begin
        req       = 1'b1;
        req_wr    = 1'b1;
        req_addr  = BASE_ADDR + 25'(idx_q);
        req_wdata = put_print ? byte_q : FILL_CHAR;
        state_d   = PUT_WAIT;
      end
      PUT_WAIT: begin
        if (done) begin
          if (put_print && (col_q == LAST_COL) && (row_q == LAST_ROW)) state_d = SCR_RD;
          else                                                       state_d = DONE;
        end
      end
      SCR_RD: begin
        req      = 1'b1;
        req_addr = BASE_ADDR + 25'(scr_idx_q) + 25'(COLS_W);
        state_d  = SCR_RD_WAIT;
      end
      SCR_RD_WAIT: begin
        if (done) state_d = SCR_WR;
      end
      SCR_WR: begin
        req       = 1'b1;
        req_wr    = 1'b1;
        req_addr  = BASE_ADDR + 25'(scr_idx_q);
        req_wdata = rdata;
        state_d   = SCR_WR_WAIT;
      end
      SCR_WR_WAIT: begin
        if (done) state_d = (scr_idx_q == COPY_LAST) ? BLANK : SCR_RD;
      end
      BLANK: begin
        req       = 1'b1;
        req_wr    = 1'b1;
        req_addr  = BASE_ADDR + 25'(scr_idx_q);
        req_wdata = FILL_CHAR;
        state_d   = BLANK_WAIT;
      end
      BLANK_WAIT: begin
        if (done) state_d = (scr_idx_q == LAST_IDX) ? DONE : BLANK;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Cursor, scroll index and written flag. The scroll copy continues straight
  // into the last-row blank, so BLANK always ends at the final cell; a full
  // clear simply starts that walk from cell 0.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      live_q    <= 1'b0;
      byte_q    <= '0;
      col_q     <= '0;
      row_q     <= '0;
      idx_q     <= '0;
      scr_idx_q <= '0;
      wrote_q   <= 1'b0;
    end else begin
      live_q <= 1'b1;
      if (req && req_wr)          wrote_q <= 1'b1;
      else if (state_q == DONE)   wrote_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (clear_start) begin
            col_q     <= '0;
            row_q     <= '0;
            idx_q     <= '0;
            scr_idx_q <= '0;
          end else if (accept) begin
            byte_q <= in_data;
          end
        end
        DECODE: begin
          if (byte_q == LF) begin
            col_q <= '0;
            if (row_q != LAST_ROW) begin
              row_q <= row_q + 5'd1;
              idx_q <= idx_q - {5'd0, col_q} + COLS_W;
            end else begin
              idx_q     <= LAST_ROW_IDX;
              scr_idx_q <= '0;
            end
          end else if (byte_q == CR) begin
            col_q <= '0;
            idx_q <= idx_q - {5'd0, col_q};
          end else if ((byte_q == BS) && (col_q != '0)) begin
            col_q <= col_q - 6'd1;
            idx_q <= idx_q - 11'd1;
          end else if (is_ff) begin
            col_q     <= '0;
            row_q     <= '0;
            idx_q     <= '0;
            scr_idx_q <= '0;
          end
        end
        PUT_WAIT: begin
          if (done && put_print) begin
            if (col_q != LAST_COL) begin
              col_q <= col_q + 6'd1;
              idx_q <= idx_q + 11'd1;
            end else begin
              col_q <= '0;
              if (row_q != LAST_ROW) begin
                row_q <= row_q + 5'd1;
                idx_q <= idx_q + 11'd1;
              end else begin
                idx_q     <= LAST_ROW_IDX;
                scr_idx_q <= '0;
              end
            end
          end
        end
        SCR_WR_WAIT, BLANK_WAIT: begin
          if (done) scr_idx_q <= scr_idx_q + 11'd1;
        end
        default: ;
      endcase
    end
  end

  sdram_ch_req u_ch (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .req      (req),
    .is_write (req_wr),
    .addr     (req_addr),
    .wdata    (req_wdata),
    .done     (done),
    .rdata    (rdata),
    .ch_addr  (ch_addr),
    .ch_wr    (ch_wr),
    .ch_rd    (ch_rd),
    .ch_din   (ch_din),
    .ch_dout  (ch_dout),
    .ch_busy  (ch_busy)
  );

endmodule
